// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - 8-requester round-robin arbiter with registered grant and optional hold limit
module rr_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam bit         UNLIMITED = (MAX_HOLD == 0);
    localparam logic [7:0] HOLD_LIM  = 8'(MAX_HOLD);

    state_t     state;
    logic [2:0] ptr;
    logic [7:0] hold_cnt;

    logic       found;
    logic [2:0] win;
    logic [2:0] cand;
    logic       keep;
    logic       load_grant;
    logic       go_idle;

    // First asserted request in the order ptr, ptr+1, ... wrapping mod 8.
    always_comb begin
        found = 1'b0;
        win   = 3'd0;
        cand  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            cand = ptr + 3'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        keep       = req[gnt_idx] && (UNLIMITED || (hold_cnt < HOLD_LIM));
        load_grant = found && ((state == IDLE) || !keep);
        go_idle    = (state == GRANT) && !keep && !found;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            hold_cnt  <= 8'd0;
            gnt       <= 8'h00;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
        end else if (load_grant) begin
            // Covers both a fresh win and a re-grant of the same owner after timeout.
            state     <= GRANT;
            gnt       <= 8'h01 << win;
            gnt_idx   <= win;
            gnt_valid <= 1'b1;
            ptr       <= win + 3'd1;
            hold_cnt  <= 8'd1;
        end else if (go_idle) begin
            state     <= IDLE;
            gnt       <= 8'h00;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            hold_cnt  <= 8'd0;
        end else if (state == GRANT && hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - scoreboard bench for rr_arbiter_8 with unlimited and 4-cycle hold instances
module tb_rr_arbiter_8;

    typedef struct {
        bit         sel;
        logic [2:0] idx;
        bit         valid;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;

    logic [7:0] g0, g4;
    logic [2:0] i0, i4;
    logic       v0, v4;

    int n_checks = 0;
    int n_pass   = 0;
    int n_step   = 0;
    exp_t exp_q[$];

    rr_arbiter_8 dut0 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(g0), .gnt_idx(i0), .gnt_valid(v0)
    );

    rr_arbiter_8 #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(g4), .gnt_idx(i4), .gnt_valid(v4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] ag, input logic [2:0] ai,
                         input logic av, input logic [7:0] eg, input logic [2:0] ei, input logic ev);
        n_checks++;
        if (ag === eg && ai === ei && av === ev) n_pass++;
        else $display("FAIL %s: got gnt=%h idx=%0d valid=%b, expected gnt=%h idx=%0d valid=%b",
                      name, ag, ai, av, eg, ei, ev);
    endtask

    // Drive req for the next edge and queue the outputs that edge must produce.
    task automatic step(input bit sel, input logic [7:0] r, input logic [2:0] idx, input bit valid);
        exp_t e;
        @(negedge clk);
        req = r;
        e.sel = sel;
        e.idx = idx;
        e.valid = valid;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req = 8'h00;
        rst_n = 1'b0;
        #1;
        check("reset0", g0, i0, v0, 8'h00, 3'd0, 1'b0);
        check("reset4", g4, i4, v4, 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                logic [7:0] eg;
                e = exp_q.pop_front();
                eg = e.valid ? (8'h01 << e.idx) : 8'h00;
                n_step++;
                if (e.sel) check($sformatf("step%0d_mh4", n_step), g4, i4, v4, eg, e.idx, e.valid);
                else       check($sformatf("step%0d_mh0", n_step), g0, i0, v0, eg, e.idx, e.valid);
            end
        end
    end

    initial begin
        do_reset();

        repeat (5) step(0, 8'h00, 3'd0, 0);

        step(0, 8'h08, 3'd3, 1);
        repeat (5) step(0, 8'h08, 3'd3, 1);
        step(0, 8'h00, 3'd0, 0);
        step(0, 8'h00, 3'd0, 0);

        // Each owner drops its request after two granted cycles.
        do_reset();
        step(0, 8'hFF, 3'd0, 1);
        for (int k = 0; k < 8; k++) begin
            step(0, 8'hFF, 3'(k), 1);
            step(0, ~(8'h01 << k), 3'(k + 1), 1);
        end

        do_reset();
        step(0, 8'h40, 3'd6, 1);
        step(0, 8'h81, 3'd7, 1);
        step(0, 8'h81, 3'd7, 1);
        step(0, 8'h01, 3'd0, 1);
        step(0, 8'h01, 3'd0, 1);
        step(0, 8'h00, 3'd0, 0);

        do_reset();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                step(1, 8'h05, (r == 1) ? 3'd2 : 3'd0, 1);
        repeat (9) step(1, 8'h01, 3'd0, 1);

        do_reset();
        step(0, 8'h20, 3'd5, 1);
        step(0, 8'h20, 3'd5, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_mh0", g0, i0, v0, 8'h00, 3'd0, 1'b0);
        check("async_rst_mh4", g4, i4, v4, 8'h00, 3'd0, 1'b0);
        #1;
        rst_n = 1'b1;
        step(0, 8'hE0, 3'd5, 1);
        step(0, 8'hE0, 3'd5, 1);
        step(0, 8'h00, 3'd0, 0);

        for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
